stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit valid/ready stream multiplexer with a registered output stage: the sequential successor of the team's 2:1 bit multiplexer. It selects one input channel per cycle, either by an external select (fixed mode) or by a round-robin arbiter. The selected beat is forwarded through one output register. It sits between multiple producer streams (adder result lanes) and a single consumer.

---
 rtl/stream_mux_rr.sv | 135 +++++++++++++
 tb/tb_stream_mux_rr.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel valid/ready stream mux, fixed or round-robin select, registered output.
// Optional per-channel burst grants when MUX_BURST_EN is defined.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int BURST    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  if (BURST < 1 || CHANNELS < 2 || CHANNELS > 16 || (1 << SEL_W) < CHANNELS) begin : g_param_check
    $error("stream_mux_rr: illegal parameter combination");
  end

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] g;
  logic             gv;
  logic [WIDTH-1:0] gdata;
  logic             load_en;
  logic             accept;
  logic [SEL_W-1:0] ptr_step;

  assign load_en  = !out_valid || out_ready;
  assign accept   = !rst && load_en && gv;
  assign ptr_step = (g == LAST) ? '0 : g + 1'b1;

  // Round-robin: lowest valid channel at or above ptr, otherwise wrap to the lowest valid one.
  always_comb begin
    g  = sel;
    gv = 1'b0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i)) gv = in_valid[i];
      end
    end else begin
      g = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!gv && in_valid[i] && SEL_W'(i) >= ptr) begin
          g  = SEL_W'(i);
          gv = 1'b1;
        end
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (!gv && in_valid[i]) begin
          g  = SEL_W'(i);
          gv = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gdata    = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (g == SEL_W'(i)) begin
        gdata       = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= gdata;
        out_chan <= g;
      end
    end
  end

`ifdef MUX_BURST_EN
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bnext;
  logic             bact;
  logic [SEL_W-1:0] lc;
  logic             burst_end;

  // ptr parks on the bursting channel, so the normal scan keeps granting it until the burst ends.
  assign bnext     = (bact && g == lc) ? bcnt + 1'b1 : '0;
  assign burst_end = (bnext >= BW'(BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      bcnt <= '0;
      bact <= 1'b0;
      lc   <= '0;
    end else if (accept && mode) begin
      lc <= g;
      if (burst_end) begin
        bcnt <= '0;
        bact <= 1'b0;
        ptr  <= ptr_step;
      end else begin
        bcnt <= bnext;
        bact <= 1'b1;
        ptr  <= g;
      end
    end else if (!mode) begin
      bcnt <= '0;
      bact <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && mode) begin
      ptr <= ptr_step;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - directed self-checking bench for stream_mux_rr.
module tb_stream_mux_rr;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 3;
  localparam int B  = 2;
`ifdef MUX_BURST_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [C*W-1:0] DATA = {8'h44, 8'h33, 8'h22, 8'h11};

  logic           clk = 1'b0;
  logic           rst;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_chan;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW), .BURST(B)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = '0;
    in_data = DATA;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = 4'hF; out_ready = 1'b1; in_data = DATA;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_comb: got %b expected 0000", in_ready); end
    step(); step();
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", out_valid); end
    checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL reset_first_chan: got %0d expected 0", out_chan); end
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL reset_first_data: got %h expected 11", out_data); end
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; out_ready = 1'b1;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
    step();
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fixed_out_data: got %h expected a5", out_data); end
    checks++; if (out_chan !== 3'd2) begin errors++; $display("FAIL fixed_out_chan: got %0d expected 2", out_chan); end
    sel = 3'd5; in_valid = 4'hF;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_oob_in_ready: got %b expected 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_oob_out_valid: got %b expected 0", out_valid); end
    in_data = DATA;
  endtask

  task automatic test_round_robin();
`ifdef MUX_BURST_EN
    int exp_ch[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int n = 8;
`else
    int exp_ch[8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    int n = 5;
`endif
    logic [7:0] exp_d;
    logic [3:0] exp_r;
    apply_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_r = 4'b0001 << exp_ch[k];
      exp_d = 8'h11 * 8'(exp_ch[k] + 1);
      #1;
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, exp_r); end
      step();
      checks++; if (out_chan !== 3'(exp_ch[k])) begin errors++; $display("FAIL rr_out_chan[%0d]: got %0d expected %0d", k, out_chan, exp_ch[k]); end
      checks++; if (out_data !== exp_d) begin errors++; $display("FAIL rr_out_data[%0d]: got %h expected %h", k, out_data, exp_d); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_out_valid[%0d]: got %b expected 1", k, out_valid); end
    end
  endtask

  task automatic test_backpressure();
`ifdef MUX_BURST_EN
    int nxt = 0;
`else
    int nxt = 1;
`endif
    logic [7:0] exp_d;
    apply_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL bp_out_chan[%0d]: got %0d expected 0", k, out_chan); end
      checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL bp_out_data[%0d]: got %h expected 11", k, out_data); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== (4'b0001 << nxt)) begin errors++; $display("FAIL bp_release_ready: got %b expected %b", in_ready, 4'b0001 << nxt); end
    step();
    exp_d = 8'h11 * 8'(nxt + 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b expected 1", out_valid); end
    checks++; if (out_chan !== 3'(nxt)) begin errors++; $display("FAIL bp_release_chan: got %0d expected %0d", out_chan, nxt); end
    checks++; if (out_data !== exp_d) begin errors++; $display("FAIL bp_release_data: got %h expected %h", out_data, exp_d); end
  endtask

  task automatic test_sparse();
`ifdef MUX_BURST_EN
    int exp_ch[3] = '{3, 3, 1};
`else
    int exp_ch[3] = '{3, 1, 3};
`endif
    logic [3:0] exp_r;
    apply_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b0010;
    repeat (NB) step();
    in_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      exp_r = 4'b0001 << exp_ch[k];
      #1;
      checks++; if (in_ready !== exp_r) begin errors++; $display("FAIL sparse_in_ready[%0d]: got %b expected %b", k, in_ready, exp_r); end
      step();
      checks++; if (out_chan !== 3'(exp_ch[k])) begin errors++; $display("FAIL sparse_out_chan[%0d]: got %0d expected %0d", k, out_chan, exp_ch[k]); end
    end
    in_valid = 4'b0010;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL sparse_drop_ready: got %b expected 0010", in_ready); end
    step();
    checks++; if (out_chan !== 3'd1) begin errors++; $display("FAIL sparse_drop_chan: got %0d expected 1", out_chan); end
    checks++; if (out_data !== 8'h22) begin errors++; $display("FAIL sparse_drop_data: got %h expected 22", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sparse_drop_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b expected 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", out_data); end
    checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL mid_reset_chan: got %0d expected 0", out_chan); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_reset_ptr: got %b expected 0001", in_ready); end
    step();
    checks++; if (out_chan !== 3'd0) begin errors++; $display("FAIL mid_reset_first_chan: got %0d expected 0", out_chan); end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
